fifo_rd_port: RTL

- Read-side controller for the asynchronous FIFO's dual-port memory, in the read clock domain.
- Owns the binary and Gray read pointers and drives the memory read address.
- Compares its pointer against the write pointer (already synchronized into the read domain) to produce empty, almost-empty and occupancy.
- Prefetches words from memory into a registered valid/ready output stage with one-word-per-cycle throughput.

---
 rtl/fifo_rd_port.sv | 107 ++++++++++
 1 files changed

// File: rtl/fifo_rd_port.sv
// fifo_rd_port
// Read-side controller of an asynchronous FIFO, living entirely in the read
// clock domain. It owns the binary/Gray read pointers, addresses the FIFO's
// dual-port memory (asynchronous read), derives empty / almost-empty /
// occupancy from the synchronized Gray write pointer, and prefetches words
// into a registered valid/ready output stage that sustains one word per cycle.
//
// Ports:
//   rclk       read-domain clock
//   rrst       asynchronous active-high reset
//   rq2_wptr   Gray write pointer, already synchronized to rclk
//   mem_rdata  combinational memory read data at raddr
//   raddr      memory read address (straight from the binary read pointer)
//   rptr       registered Gray read pointer, sent to the write domain
//   rempty     memory holds no unread word (registered)
//   rcount     words in memory not yet popped (registered)
//   raempty    rcount <= AEMPTY_THRESH (registered)
//   rdata      output data register
//   rvalid     rdata holds a word
//   rready     consumer accepts rdata when rvalid
//
// Handshake: a word moves to the consumer on every rclk edge where
// rvalid && rready are both high. While rvalid is high and rready is low,
// rdata/rvalid are held stable. rready is ignored while rvalid is low.

module fifo_rd_port #(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                raempty,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    input  logic                rready
);

    localparam logic [ADDRSIZE:0] AE_LIMIT = (ADDRSIZE + 1)'(AEMPTY_THRESH);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wdiff;
    logic              pop;

    // Pull a word out of memory whenever one is available and the output
    // register is either empty or being drained on this same edge.
    always_comb begin
        pop       = !rempty && (!rvalid || rready);
        rbinnext  = rbin + {{ADDRSIZE{1'b0}}, pop};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
    end

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above
    // it. Works for arbitrary jumps of the synchronized write pointer.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    // Occupancy after this edge's pop; the extra MSB makes full (2^ADDRSIZE)
    // distinguishable from empty.
    always_comb wdiff = wbin - rbinnext;

    assign raddr = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            rcount  <= '0;
            raempty <= 1'b1;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            // Full-width compare: the MSB separates "same slot, same lap"
            // (empty) from "same slot, one lap apart" (full).
            rempty  <= (rgraynext == rq2_wptr);
            rcount  <= wdiff;
            raempty <= (wdiff <= AE_LIMIT);
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (pop) begin
            rdata  <= mem_rdata;
            rvalid <= 1'b1;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule
